// File: rtl/alu_seq16_if.sv
// Bundle of the sequencer's request/response signals and its byte-wide ALU link.
// The slave modport is the sequencer; the master modport is the core/ALU side.
interface alu_seq16_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic        carry_flag;
  logic        parity_flag;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_sc_i;
  logic        alu_pari_in;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;
  logic        alu_sc_en;
  logic        alu_sc_clr;
  logic        alu_pari;
  logic        alu_pari_clr;

  modport master (
    output start, op, a, b, carry_in,
    output alu_rslt, alu_sc_o, alu_sc_en, alu_sc_clr, alu_pari, alu_pari_clr,
    input  busy, done, err, result, carry_flag, parity_flag,
    input  alu_cmd, alu_a, alu_b, alu_sc_i, alu_pari_in
  );

  modport slave (
    input  start, op, a, b, carry_in,
    input  alu_rslt, alu_sc_o, alu_sc_en, alu_sc_clr, alu_pari, alu_pari_clr,
    output busy, done, err, result, carry_flag, parity_flag,
    output alu_cmd, alu_a, alu_b, alu_sc_i, alu_pari_in
  );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer: chains two byte-wide passes of the 8-bit ALU
// through the shift-carry and parity flags, which this block owns.
module alu_seq16 (
  input  logic       clk,
  input  logic       reset,
  alu_seq16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, FIN} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_LSR = 3'd2;
  localparam logic [2:0] OP_ASR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_PAR = 3'd5;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_LSL = 4'd2;
  localparam logic [3:0] CMD_ASR = 4'd3;
  localparam logic [3:0] CMD_LSR = 4'd4;
  localparam logic [3:0] CMD_XOR = 4'd7;
  localparam logic [3:0] CMD_PAR = 4'd8;

  state_t      state, next_state;
  logic [15:0] a_q, b_q, result_q;
  logic [2:0]  op_q;
  logic        cin_q, carry_q, parity_q, done_q, err_q, illegal_q;
  logic        in_pass, first, pass_hi, accept, op_legal;
  logic [3:0]  cmd;
  logic [7:0]  opa, opb;
  logic        sc_i, pari_in;

  assign in_pass  = (state == FIRST) || (state == SECOND);
  assign first    = (state == FIRST);
  // Right shifts walk high byte first so the bit leaving the high byte feeds the low byte.
  assign pass_hi  = ((op_q == OP_LSR) || (op_q == OP_ASR)) ? first : !first;
  assign op_legal = (bus.op <= OP_PAR);
  // An illegal op parks one cycle in IDLE (illegal_q) before FIN; no new start meanwhile.
  assign accept   = (state == IDLE) && bus.start && !illegal_q;

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (illegal_q)               next_state = FIN;
        else if (accept && op_legal) next_state = FIRST;
      end
      FIRST:   next_state = SECOND;
      SECOND:  next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd     = CMD_ADD;
    opa     = 8'h00;
    opb     = 8'h00;
    sc_i    = 1'b0;
    pari_in = 1'b0;
    if (in_pass) begin
      opa = pass_hi ? a_q[15:8] : a_q[7:0];
      opb = pass_hi ? b_q[15:8] : b_q[7:0];
      case (op_q)
        OP_ADD: begin
          cmd  = CMD_ADD;
          sc_i = first ? cin_q : carry_q;
        end
        OP_SHL: begin
          cmd  = CMD_LSL;
          sc_i = !first && carry_q;
        end
        OP_LSR: begin
          cmd  = CMD_LSR;
          sc_i = !first && carry_q;
        end
        OP_ASR: begin
          cmd  = first ? CMD_ASR : CMD_LSR;
          sc_i = !first && carry_q;
        end
        OP_XOR: cmd = CMD_XOR;
        OP_PAR: begin
          cmd     = CMD_PAR;
          pari_in = !first && parity_q;
        end
        default: cmd = CMD_ADD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      op_q      <= 3'd0;
      cin_q     <= 1'b0;
      result_q  <= 16'h0000;
      carry_q   <= 1'b0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == FIN);
      err_q  <= (state == FIN) && illegal_q;
      if (state == FIN) illegal_q <= 1'b0;

      if (accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        op_q      <= bus.op;
        cin_q     <= bus.carry_in;
        illegal_q <= !op_legal;
      end

      if (in_pass) begin
        if (bus.alu_sc_clr)     carry_q <= 1'b0;
        else if (bus.alu_sc_en) carry_q <= bus.alu_sc_o;
        parity_q <= bus.alu_pari_clr ? 1'b0 : bus.alu_pari;
        if (op_q == OP_PAR) result_q <= 16'h0000;
        else if (pass_hi)   result_q[15:8] <= bus.alu_rslt;
        else                result_q[7:0]  <= bus.alu_rslt;
      end
    end
  end

  assign bus.busy        = in_pass;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.result      = result_q;
  assign bus.carry_flag  = carry_q;
  assign bus.parity_flag = parity_q;
  assign bus.alu_cmd     = cmd;
  assign bus.alu_a       = opa;
  assign bus.alu_b       = opb;
  assign bus.alu_sc_i    = sc_i;
  assign bus.alu_pari_in = pari_in;
endmodule

// File: doc/alu_seq16.md
Name: alu_seq16

Overview:
- Multi-cycle sequencer that drives the 8-bit ALU to perform 16-bit operations, as two byte-wide ALU passes chained through the shift-carry and parity flags.
- Sits between the core control path and the ALU: it generates alu_cmd, the operands, sc_i and pari_in, and consumes rslt and the flag outputs.
- It also owns the architectural carry and parity flag registers.

Parameters:
- None.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0 ADD16, 1 SHL16, 2 LSR16, 3 ASR16, 4 XOR16, 5 PAR16, 6-7 illegal
a  in  16  operand A, captured at start
b  in  16  operand B, captured at start
carry_in  in  1  initial carry for ADD16 only
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  high with done for an illegal op
result  out  16  registered 16-bit result
carry_flag  out  1  shift-carry flag register
parity_flag  out  1  parity flag register
alu_cmd  out  4  ALU command (0 add, 2 lsl, 3 asr, 4 lsr, 7 xor, 8 parity)
alu_a  out  8  ALU inA
alu_b  out  8  ALU inB
alu_sc_i  out  1  ALU shift-carry in
alu_pari_in  out  1  ALU parity in
alu_rslt  in  8  ALU result
alu_sc_o  in  1  ALU carry out
alu_sc_en  in  1  load carry_flag with alu_sc_o
alu_sc_clr  in  1  clear carry_flag
alu_pari  in  1  ALU parity out
alu_pari_clr  in  1  1 = clear parity_flag, 0 = load alu_pari

Behaviour:
- Reset values: state IDLE; busy, done and err 0; result 0x0000; carry_flag 0; parity_flag 0; operand registers 0.
- Reset wins over every other input in every state. A reset mid-operation aborts the operation, and no done is produced.
- FSM states: IDLE -> FIRST -> SECOND -> FIN -> IDLE.
  - Illegal op: IDLE -> FIN directly, with err=1. result and both flags stay unchanged.
- IDLE:
  - With start=1, captures a, b, op and carry_in.
  - start=0 leaves all registers unchanged.
  - start in any other state is ignored; it is not queued.
  - ALU outputs are driven to cmd 0 with all operands 0. Flags are not updated in IDLE or FIN.
- Flag update: only in FIRST and SECOND, at the clock edge.
  - carry_flag: alu_sc_clr -> 0; else alu_sc_en -> alu_sc_o; else hold.
  - parity_flag: alu_pari_clr -> 0; else alu_pari.
- Byte order: low byte first for ADD16, SHL16, XOR16 and PAR16; high byte first for LSR16 and ASR16.
- FIRST and SECOND each drive one ALU pass; alu_rslt is captured into the corresponding result byte.
  - ADD16: cmd 0 both passes. sc_i = carry_in, then carry_flag.
  - SHL16: cmd 2 both passes. sc_i = 0, then carry_flag.
  - LSR16: cmd 4 both passes. sc_i = 0 on the high byte, then carry_flag on the low byte.
  - ASR16: cmd 3 on the high byte, then cmd 4 on the low byte with sc_i = carry_flag.
  - XOR16: cmd 7 both passes; alu_sc_clr clears carry_flag.
  - PAR16: cmd 8 on the low byte with pari_in = 0, then on the high byte with pari_in = parity_flag. result is written 0x0000; carry_flag ends at 0.
- FIN: done=1 for exactly one cycle; busy=0 in FIN and IDLE.
- Latency: start sampled at edge k -> done high during the cycle following edge k+3.
  - Illegal op: done high during the cycle following edge k+2.
- result and both flags hold their values until the next accepted start.
- carry_flag carries over from a previous operation only where a pass uses it. Every op sets it explicitly on its first pass, except illegal ops.

Test Plan:
- Reset, then ADD16 a=0x00FF, b=0x0001, carry_in=0 -> result 0x0100, carry_flag 0, done exactly 3 cycles after start, busy high for 2 cycles.
- ADD16 a=0xFFFF, b=0x0001, carry_in=1 -> result 0x0001, carry_flag 1; then XOR16 a=0x1234, b=0x00FF -> result 0x12CB, carry_flag 0.
- SHL16 a=0x8081 -> 0x0102, carry 1; LSR16 a=0x0101 -> 0x0080, carry 1; ASR16 a=0x8001 -> 0xC000, carry 1.
- PAR16 a=0x0107 -> parity_flag 0, result 0x0000; PAR16 a=0x0307 -> parity_flag 1.
- ADD16 started, reset asserted while in SECOND -> next cycle busy 0, result 0x0000, flags 0, no done pulse; a new start then completes normally.
- op=6 -> done and err high together 2 cycles after start, result and flags unchanged; start pulsed while busy=1 -> ignored, exactly one done.
